// File: rtl/hero_write_rx_if.sv
// Bus-side and downstream-side bundles for the hero write receiver.
// hero_bus_if carries one beat per cycle with no backpressure; hero_beat_if is a valid/ready stream.
interface hero_bus_if #(
  parameter int HERO_WIDTH = 36,
  parameter int SUB_W      = 7
);
  logic [1:0]            hw_cycle_type;
  logic [HERO_WIDTH-1:0] hw_wdat;
  logic [SUB_W-1:0]      hw_sub;
  logic                  hw_clk_en;

  modport master (output hw_cycle_type, hw_wdat, hw_sub, hw_clk_en);
  modport slave  (input  hw_cycle_type, hw_wdat, hw_sub, hw_clk_en);
endinterface

interface hero_beat_if #(
  parameter int HERO_WIDTH = 36,
  parameter int SUB_W      = 7,
  parameter int IDX_W      = 2
);
  logic                  out_valid;
  logic                  out_ready;
  logic [HERO_WIDTH-1:0] out_wdat;
  logic [SUB_W-1:0]      out_sub;
  logic                  out_last;
  logic                  out_err;
  logic [IDX_W-1:0]      out_beat_idx;

  modport master (output out_valid, out_wdat, out_sub, out_last, out_err, out_beat_idx,
                  input  out_ready);
  modport slave  (input  out_valid, out_wdat, out_sub, out_last, out_err, out_beat_idx,
                  output out_ready);
endinterface

// File: rtl/hero_write_rx.sv
// Frames hero write bus beats into transactions, admits whole transactions into a
// first-word-fall-through beat FIFO and tracks delivery/drop/error status.
module hero_write_rx #(
  parameter int DEPTH      = 16,
  parameter int MAX_BEATS  = 4,
  parameter int CNT_W      = 16,
  parameter int HERO_WIDTH = 36,
  parameter int SUB_W      = 7
) (
  input  logic             clk,
  input  logic             rst,
  hero_bus_if.slave        hw_bus,
  hero_beat_if.master      out_bus,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             err_len,
  output logic             err_proto
);
  localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {CT_IDLE = 2'd0, CT_VALID = 2'd1, CT_DONE = 2'd2, CT_RSVD = 2'd3} cycle_type_e;
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DISCARD} state_e;

  typedef struct packed {
    logic [HERO_WIDTH-1:0] wdat;
    logic [SUB_W-1:0]      sub;
    logic                  last;
    logic                  err;
    logic [IDX_W-1:0]      idx;
  } beat_t;

  cycle_type_e ct;
  logic        beat_ok, is_done, proto_hit;

  assign ct        = cycle_type_e'(hw_bus.hw_cycle_type);
  assign beat_ok   = hw_bus.hw_clk_en && (ct == CT_VALID || ct == CT_DONE);
  assign is_done   = (ct == CT_DONE);
  assign proto_hit = hw_bus.hw_clk_en && (ct == CT_RSVD);

  // ---------------- FIFO state ----------------
  beat_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    occ_q, occ_d, free;
  logic           push, pop, can_admit;
  beat_t          push_beat, head;

  // Admission reserves a whole transaction's worth of space against registered occupancy.
  assign free      = (AW+1)'(DEPTH) - occ_q;
  assign can_admit = free >= (AW+1)'(MAX_BEATS);

  // ---------------- framing FSM ----------------
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, next_idx;
  logic             txn_inc, drop_inc, len_set;

  assign next_idx = idx_q + 1'b1;

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    push      = 1'b0;
    push_beat = '{wdat: hw_bus.hw_wdat, sub: hw_bus.hw_sub, last: 1'b0, err: 1'b0, idx: '0};
    txn_inc   = 1'b0;
    drop_inc  = 1'b0;
    len_set   = 1'b0;
    unique case (state_q)
      S_IDLE: if (beat_ok) begin
        if (can_admit) begin
          push = 1'b1;
          if (is_done) begin
            push_beat.last = 1'b1;
            txn_inc        = 1'b1;
          end else begin
            idx_d   = '0;
            state_d = S_ACTIVE;
          end
        end else begin
          drop_inc = 1'b1;
          if (!is_done) state_d = S_DISCARD;
        end
      end
      S_ACTIVE: if (beat_ok) begin
        push          = 1'b1;
        push_beat.idx = next_idx;
        if (is_done) begin
          push_beat.last = 1'b1;
          txn_inc        = 1'b1;
          state_d        = S_IDLE;
        end else if (next_idx == IDX_W'(MAX_BEATS - 1)) begin
          // Beat MAX_BEATS without DONE: close it off as truncated, swallow the rest.
          push_beat.last = 1'b1;
          push_beat.err  = 1'b1;
          len_set        = 1'b1;
          txn_inc        = 1'b1;
          state_d        = S_DISCARD;
        end else begin
          idx_d = next_idx;
        end
      end
      S_DISCARD: if (beat_ok && is_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FIFO datapath ----------------
  assign out_bus.out_valid = (occ_q != '0);
  assign pop               = out_bus.out_valid && out_bus.out_ready;
  assign head              = mem[rd_ptr_q];

  assign out_bus.out_wdat     = out_bus.out_valid ? head.wdat : '0;
  assign out_bus.out_sub      = out_bus.out_valid ? head.sub  : '0;
  assign out_bus.out_last     = out_bus.out_valid && head.last;
  assign out_bus.out_err      = out_bus.out_valid && head.err;
  assign out_bus.out_beat_idx = out_bus.out_valid ? head.idx  : '0;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    occ_d    = occ_q;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (!push && pop) occ_d = occ_q - 1'b1;
  end

  // NOTE: storage has no reset; validity is carried entirely by the pointers and occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_beat;
  end

  // ---------------- status ----------------
  logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d, drop_cnt_q, drop_cnt_d;
  logic             err_len_q, err_len_d, err_proto_q, err_proto_d;

  always_comb begin
    txn_cnt_d   = (txn_inc  && txn_cnt_q  != '1) ? txn_cnt_q  + 1'b1 : txn_cnt_q;
    drop_cnt_d  = (drop_inc && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    err_len_d   = err_len_q   || len_set;
    err_proto_d = err_proto_q || proto_hit;
    if (stat_clr) begin
      txn_cnt_d   = '0;
      drop_cnt_d  = '0;
      err_len_d   = 1'b0;
      err_proto_d = 1'b0;
    end
  end

  // NOTE: all state updates use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      txn_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      err_len_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      txn_cnt_q   <= txn_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      err_len_q   <= err_len_d;
      err_proto_q <= err_proto_d;
    end
  end

  assign txn_cnt   = txn_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign err_len   = err_len_q;
  assign err_proto = err_proto_q;

endmodule

// File: tb/tb_hero_write_rx.sv
// Directed plus randomized bench for hero_write_rx, checked every cycle against a
// transaction-level reference model (expected-beat queue plus status counters).
module tb_hero_write_rx;
  localparam int DEPTH     = 16;
  localparam int MAX_BEATS = 4;
  localparam int CNT_MAX   = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic        stat_clr;
  logic [15:0] txn_cnt, drop_cnt;
  logic        err_len, err_proto;

  hero_bus_if  hw_bus ();
  hero_beat_if out_bus ();

  hero_write_rx dut (
    .clk      (clk),
    .rst      (rst),
    .hw_bus   (hw_bus),
    .out_bus  (out_bus),
    .stat_clr (stat_clr),
    .txn_cnt  (txn_cnt),
    .drop_cnt (drop_cnt),
    .err_len  (err_len),
    .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] wdat;
    logic [6:0]  sub;
    logic        last;
    logic        err;
    int          idx;
  } exp_beat_t;

  exp_beat_t exp_q[$];
  int  beats_open;     // beats already accepted in the open transaction, 0 = none open
  bit  discarding;
  int  m_txn, m_drop;
  bit  m_len, m_proto;
  int  n_pass = 0, n_total = 0;
  logic rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    exp_q.delete();
    beats_open = 0; discarding = 0;
    m_txn = 0; m_drop = 0; m_len = 0; m_proto = 0;
  endtask

  function automatic exp_beat_t mk(input logic [35:0] w, input logic [6:0] s,
                                   input logic l, input logic e, input int i);
    exp_beat_t b;
    b.wdat = w; b.sub = s; b.last = l; b.err = e; b.idx = i;
    return b;
  endfunction

  // One bus cycle of the reference: occupancy is taken before this cycle's pop.
  task automatic model_cycle(input logic [1:0] ct, input logic [35:0] wd, input logic [6:0] sb,
                             input logic en, input logic rd, input logic clr);
    int  occ  = exp_q.size();
    bit  pop  = rd && (occ != 0);
    bit  done = (ct == 2'd2);
    if (pop) void'(exp_q.pop_front());
    if (en && ct == 2'd3) m_proto = 1;
    else if (en && (ct == 2'd1 || ct == 2'd2)) begin
      if (discarding) begin
        if (done) discarding = 0;
      end else if (beats_open == 0) begin
        if (DEPTH - occ >= MAX_BEATS) begin
          exp_q.push_back(mk(wd, sb, done, 1'b0, 0));
          if (done) m_txn = (m_txn < CNT_MAX) ? m_txn + 1 : m_txn;
          else      beats_open = 1;
        end else begin
          m_drop = (m_drop < CNT_MAX) ? m_drop + 1 : m_drop;
          if (!done) discarding = 1;
        end
      end else if (done) begin
        exp_q.push_back(mk(wd, sb, 1'b1, 1'b0, beats_open));
        m_txn = (m_txn < CNT_MAX) ? m_txn + 1 : m_txn;
        beats_open = 0;
      end else if (beats_open + 1 == MAX_BEATS) begin
        exp_q.push_back(mk(wd, sb, 1'b1, 1'b1, beats_open));
        m_txn = (m_txn < CNT_MAX) ? m_txn + 1 : m_txn;
        m_len = 1; beats_open = 0; discarding = 1;
      end else begin
        exp_q.push_back(mk(wd, sb, 1'b0, 1'b0, beats_open));
        beats_open++;
      end
    end
    if (clr) begin
      m_txn = 0; m_drop = 0; m_len = 0; m_proto = 0;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", out_bus.out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("out_wdat", out_bus.out_wdat, exp_q[0].wdat);
      chk("out_sub",  out_bus.out_sub,  exp_q[0].sub);
      chk("out_last", out_bus.out_last, exp_q[0].last);
      chk("out_err",  out_bus.out_err,  exp_q[0].err);
      chk("out_idx",  out_bus.out_beat_idx, exp_q[0].idx);
    end
    chk("txn_cnt",   txn_cnt,   m_txn);
    chk("drop_cnt",  drop_cnt,  m_drop);
    chk("err_len",   err_len,   m_len);
    chk("err_proto", err_proto, m_proto);
  endtask

  // Called at a falling edge: check, drive, advance the model, then move to the next falling edge.
  task automatic step(input logic [1:0] ct, input logic [35:0] wd, input logic [6:0] sb,
                      input logic en, input logic rd, input logic clr);
    check_outputs();
    hw_bus.hw_cycle_type = ct;
    hw_bus.hw_wdat       = wd;
    hw_bus.hw_sub        = sb;
    hw_bus.hw_clk_en     = en;
    out_bus.out_ready    = rd;
    stat_clr             = clr;
    model_cycle(ct, wd, sb, en, rd, clr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] ct, input logic [35:0] wd, input logic [6:0] sb = 7'h0);
    step(ct, wd, sb, 1'b1, rdy, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'd0, '0, '0, 1'b1, rdy, 1'b0);
  endtask

  task automatic do_reset();
    hw_bus.hw_cycle_type = 2'd0; hw_bus.hw_wdat = '0; hw_bus.hw_sub = '0; hw_bus.hw_clk_en = 1'b0;
    stat_clr = 1'b0;
    rst = 1'b1;
    #1;
    model_clear();
    chk("rst_valid", out_bus.out_valid, 1'b0);
    chk("rst_wdat",  out_bus.out_wdat,  36'h0);
    chk("rst_last",  out_bus.out_last,  1'b0);
    chk("rst_txn",   txn_cnt,  16'h0);
    chk("rst_drop",  drop_cnt, 16'h0);
    chk("rst_errs",  {err_len, err_proto}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rdy = 1'b1;
    out_bus.out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // Three-beat transaction, ready held high.
    send(2'd1, 36'h1); send(2'd1, 36'h2); send(2'd2, 36'h3);
    idle(3);
    chk("t1_txn", txn_cnt, 16'd1);

    // Single DONE beat.
    send(2'd2, 36'hA, 7'h55);
    idle(2);

    // Fill the FIFO with four 4-beat transactions, fifth is dropped.
    rdy = 1'b0;
    for (int t = 0; t < 4; t++) begin
      send(2'd1, 36'h100 + 36'(4*t)); send(2'd1, 36'h101 + 36'(4*t));
      send(2'd1, 36'h102 + 36'(4*t)); send(2'd2, 36'h103 + 36'(4*t));
    end
    send(2'd1, 36'hBAD); send(2'd2, 36'hBAD);
    idle(1);
    chk("full_drop", drop_cnt, 16'd1);
    chk("full_valid", out_bus.out_valid, 1'b1);
    rdy = 1'b1;
    idle(18);
    chk("drained", out_bus.out_valid, 1'b0);

    // Over-long transaction gets truncated, the next one frames normally.
    for (int i = 0; i < 6; i++) send(2'd1, 36'h200 + 36'(i));
    send(2'd2, 36'h2FF);
    send(2'd1, 36'h300); send(2'd2, 36'h301);
    idle(3);
    chk("len_err", err_len, 1'b1);

    // Gated cycles and a reserved cycle type mid-transaction.
    send(2'd1, 36'h400);
    step(2'd1, 36'hDEAD, 7'h1, 1'b0, rdy, 1'b0);
    send(2'd3, 36'hBEEF);
    send(2'd1, 36'h401);
    step(2'd2, 36'hDEAD, 7'h2, 1'b0, rdy, 1'b0);
    send(2'd2, 36'h402);
    idle(3);
    chk("proto_set", err_proto, 1'b1);
    step(2'd0, '0, '0, 1'b1, rdy, 1'b1);
    chk("clr_proto", err_proto, 1'b0);
    chk("clr_txn", txn_cnt, 16'd0);

    // Reset in the middle of an ACTIVE transaction with the FIFO non-empty.
    rdy = 1'b0;
    send(2'd1, 36'h500); send(2'd1, 36'h501);
    chk("pre_rst_valid", out_bus.out_valid, 1'b1);
    do_reset();
    rdy = 1'b1;
    send(2'd2, 36'h600, 7'h11);
    chk("post_rst_last", out_bus.out_last, 1'b1);
    idle(2);

    // Randomized traffic with varying downstream throughput.
    for (int ph = 0; ph < 6; ph++) begin
      int rdy_pct = (ph % 3 == 0) ? 10 : (ph % 3 == 1) ? 60 : 100;
      for (int i = 0; i < 120; i++) begin
        int r = $urandom_range(0, 99);
        logic [1:0] ct = (r < 10) ? 2'd0 : (r < 12) ? 2'd3 : (r < 72) ? 2'd1 : 2'd2;
        step(ct, {4'h0, 32'($urandom)}, 7'($urandom), $urandom_range(0, 9) != 0,
             $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) == 0);
      end
    end
    rdy = 1'b1;
    idle(DEPTH + 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hero_write_rx.md
Name: hero_write_rx

Overview:
- Receive end of the hero write bus, which carries one hero write beat per cycle.
- Bus fields per beat: cycle_type (2b: IDLE=0, VALID=1, DONE=2), wdat (HERO_WIDTH=36b), another_type_reference (sub_def_t, 7b), clk_en (1b).
- The bus has no backpressure. The block frames beats into transactions, admits whole transactions into a beat FIFO, and presents beats downstream on a valid/ready interface with last/error tagging and status counters.

Parameters:
- DEPTH, 16, beat FIFO entries; power of 2, must be >= MAX_BEATS.
- MAX_BEATS, 4, maximum legal beats per transaction, including the DONE beat.
- CNT_W, 16, width of the status counters.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- hw_cycle_type  in  2  CYCLE_TYPE_E encoding.
- hw_wdat  in  36  write data.
- hw_sub  in  7  sub_def_t payload.
- hw_clk_en  in  1  beat qualifier; 0 = cycle ignored entirely.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accept.
- out_wdat  out  36  head beat data.
- out_sub  out  7  head beat sub_def_t.
- out_last  out  1  head is the final beat of its transaction.
- out_err  out  1  head closes a length-truncated transaction.
- out_beat_idx  out  clog2(MAX_BEATS)  beat index within the transaction, starting at 0.
- stat_clr  in  1  synchronous pulse; clears counters and sticky flags.
- txn_cnt  out  CNT_W  transactions delivered into the FIFO; saturating.
- drop_cnt  out  CNT_W  transactions rejected at admission; saturating.
- err_len  out  1  sticky: a transaction exceeded MAX_BEATS.
- err_proto  out  1  sticky: cycle_type==3 seen with clk_en=1.

Behaviour:
- Reset values: every output 0; FIFO empty; state IDLE.
- Reset asserted mid-transaction flushes the FIFO and all partial state. Bus beats arriving after reset release are framed from IDLE; a trailing VALID/DONE starts a new transaction.
- Qualified beat: hw_clk_en=1 and cycle_type is VALID or DONE. cycle_type IDLE means no beat. cycle_type 3 sets err_proto, is otherwise ignored, and causes no state change.
- Admission:
  - Checked on the first qualified beat seen in IDLE.
  - free = DEPTH - occupancy, using registered occupancy; a same-cycle pop is not credited.
  - free >= MAX_BEATS: admit and write the beat.
  - Otherwise: drop_cnt++ and go to DISCARD (a DONE first beat counts as dropped and stays in IDLE).
- FSM:
  - IDLE: VALID admitted -> write with idx 0, last=0, go to ACTIVE. DONE admitted -> write with last=1, txn_cnt++, stay IDLE.
  - ACTIVE: VALID -> write with idx+1. If that beat is number MAX_BEATS, force last=1, err=1, set err_len, txn_cnt++, go to DISCARD. DONE -> write with last=1, txn_cnt++, go to IDLE.
  - DISCARD: all beats ignored; DONE -> IDLE.
- Reservation at admission guarantees no FIFO overflow within an admitted transaction.
- FIFO is a standard first-word-fall-through buffer:
  - A beat captured at edge N is visible on out_* after edge N, so one-cycle latency when the FIFO is empty.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- out_* stable while out_valid=1 and out_ready=0.
- Counters saturate at 2^CNT_W-1.
- stat_clr zeroes counters and sticky flags. An increment in the same cycle as stat_clr is lost (clear wins).

Test Plan:
- Beats VALID(wdat=0x1),VALID(0x2),DONE(0x3) with out_ready=1 -> out beats 0x1/0x2/0x3, idx 0/1/2, last only on 0x3, first out_valid one cycle after the first beat, txn_cnt=1.
- Single DONE beat from IDLE, wdat=0xA, sub=0x55 -> one out beat, last=1, idx=0, out_sub=0x55.
- out_ready=0; send four 4-beat transactions (16 beats) then a 5th transaction -> FIFO holds 16 beats, 5th dropped, drop_cnt=1. Release ready -> 16 beats in order with correct last flags.
- VALIDx6 then DONE (MAX_BEATS=4) -> 4 beats out, 4th has last=1/err=1, err_len=1, remaining beats discarded, next transaction framed normally.
- clk_en=0 cycles interleaved mid-transaction, plus one cycle_type=3 beat -> those cycles ignored, framing intact, err_proto=1; stat_clr -> err_proto=0, txn_cnt=0.
- Assert rst after 2 beats of an ACTIVE transaction with FIFO non-empty -> out_valid=0 and counters 0 immediately. A following DONE after release is treated as a 1-beat transaction.
